bist_stim_gen: RTL

- Stimulus-side counterpart to the design's MISR response compactors.
- Sequences a self-test run:
  - resets the downstream MISR;
  - drives an LFSR-generated pattern stream onto the DUT primary inputs;
  - waits for compactor latency;
  - compares the returned signature against a golden value.
- Sits between the test controller (start/abort, golden) and the DUT input pins / MISR reset.

---
 rtl/bist_stim_gen_if.sv | 32 +++
 rtl/bist_stim_gen.sv | 116 +++++++++++
 2 files changed

// File: rtl/bist_stim_gen_if.sv
// rtl/bist_stim_gen_if.sv - controller/DUT-side bus of the BIST stimulus generator
// master drives run control and the returned signature; slave is the generator.
interface bist_stim_gen_if #(
  parameter int WIDTH = 3,
  parameter int SIG_W = 3,
  parameter int OUT_W = 2,
  parameter int PW    = 3
);
  logic             start;
  logic             abort;
  logic [WIDTH-1:0] seed;
  logic [SIG_W-1:0] golden;
  logic [SIG_W-1:0] sig_in;
  logic [OUT_W-1:0] stim;
  logic             stim_valid;
  logic             misr_rst;
  logic             busy;
  logic [PW-1:0]    pat_cnt;
  logic             done;
  logic             pass;
  logic             fail;

  modport master (
    output start, abort, seed, golden, sig_in,
    input  stim, stim_valid, misr_rst, busy, pat_cnt, done, pass, fail
  );

  modport slave (
    input  start, abort, seed, golden, sig_in,
    output stim, stim_valid, misr_rst, busy, pat_cnt, done, pass, fail
  );
endinterface

// File: rtl/bist_stim_gen.sv
// rtl/bist_stim_gen.sv - LFSR stimulus sequencer for a MISR-compacted self-test run
// IDLE -> INIT (MISR reset) -> RUN (patterns) -> DRAIN (compactor latency) -> CHECK.
module bist_stim_gen #(
  parameter int               WIDTH   = 3,
  parameter logic [WIDTH-1:0] TAPS    = 3'b110,
  parameter int               OUT_W   = 2,
  parameter int               NUM_PAT = 7,
  parameter int               DRAIN   = 2,
  parameter int               SIG_W   = 3
) (
  input logic            clk,
  input logic            rst,
  bist_stim_gen_if.slave bus
);
  localparam int PW = $clog2(NUM_PAT + 1);
  localparam int DW = $clog2(DRAIN + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_RUN,
    S_DRAIN,
    S_CHECK
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [SIG_W-1:0] golden_q, golden_d;
  logic [PW-1:0]    pat_cnt_q, pat_cnt_d;
  logic [DW-1:0]    drain_cnt_q, drain_cnt_d;
  logic             pass_q, pass_d;
  logic             fail_q, fail_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      lfsr_q      <= WIDTH'(1);
      golden_q    <= '0;
      pat_cnt_q   <= '0;
      drain_cnt_q <= '0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      golden_q    <= golden_d;
      pat_cnt_q   <= pat_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    golden_d    = golden_q;
    pat_cnt_d   = pat_cnt_q;
    drain_cnt_d = drain_cnt_q;
    pass_d      = pass_q;
    fail_d      = fail_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d   = S_INIT;
          // an all-zero seed would lock the LFSR, so it is promoted to 1
          lfsr_d    = (bus.seed == '0) ? WIDTH'(1) : bus.seed;
          golden_d  = bus.golden;
          pat_cnt_d = '0;
          pass_d    = 1'b0;
          fail_d    = 1'b0;
        end
      end
      S_INIT: begin
        state_d = bus.abort ? S_IDLE : S_RUN;
      end
      S_RUN: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else begin
          lfsr_d    = {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAPS)};
          pat_cnt_d = pat_cnt_q + PW'(1);
          if (pat_cnt_q == PW'(NUM_PAT - 1)) begin
            state_d     = S_DRAIN;
            drain_cnt_d = '0;
          end
        end
      end
      S_DRAIN: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (drain_cnt_q == DW'(DRAIN - 1)) begin
          state_d = S_CHECK;
        end else begin
          drain_cnt_d = drain_cnt_q + DW'(1);
        end
      end
      S_CHECK: begin
        pass_d  = (bus.sig_in == golden_q);
        fail_d  = (bus.sig_in != golden_q);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // outputs decode registered state only, so no input reaches an output combinationally
  assign bus.stim       = (state_q == S_RUN) ? lfsr_q[OUT_W-1:0] : '0;
  assign bus.stim_valid = (state_q == S_RUN);
  assign bus.misr_rst   = (state_q == S_INIT);
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.done       = (state_q == S_CHECK);
  assign bus.pat_cnt    = pat_cnt_q;
  assign bus.pass       = pass_q;
  assign bus.fail       = fail_q;
endmodule
